nand_target_arbiter: RTL and testbench
======================================

Name: nand_target_arbiter

Overview:
- Parametrised N-target successor to the fixed 2-CE / 4-RB wiring of the current NAND bench/controller pairing.
- Arbitrates one shared DQ/DQS/CLE/ALE bus among NUM_TARGETS NAND targets; drives active-low CE per target.
- Synchronises each RB# pin, masks the post-command tWB window, and flags targets stuck busy.
- Sits between the controller's command sequencer and the NAND pins.

Parameters:
- NUM_TARGETS, 4, number of CE/RB pairs, 1..8.
- SYNC_STAGES, 2, RB# synchroniser depth, >=2.
- CE_SETUP, 2, cycles from CE# low to grant.
- CE_HOLD, 2, cycles CE# stays high in RELEASE before the next grant.
- TWB_CYC, 10, cycles target_ready is forced low after a busy-causing op.
- TIMEOUT_W, 20, busy timeout counter width.
- TIMEOUT_CYC, 1000000, busy cycles before timeout_err; must be < 2^TIMEOUT_W.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- rb_n_in  in  NUM_TARGETS  raw asynchronous RB# pins; 1 means ready.
- req_valid  in  NUM_TARGETS  per-target bus request; held high until op_done.
- op_done  in  1  one-cycle pulse: sequencer finished the bus phase on the granted target.
- op_expect_busy  in  1  qualifies op_done: the op makes the target go busy (program, erase, read).
- err_clr  in  NUM_TARGETS  clears timeout_err bits.
- cen  out  NUM_TARGETS  active-low chip enables.
- grant  out  NUM_TARGETS  one-hot bus grant.
- bus_busy  out  1  high in any state except IDLE.
- target_ready  out  NUM_TARGETS  synchronised, tWB-masked ready.
- timeout_err  out  NUM_TARGETS  sticky busy-timeout flags.

Behaviour:
- Reset (async assert, sync deassert via RST_N):
  - cen all 1s; grant 0; bus_busy 0; timeout_err 0.
  - Synchroniser flops 1, so target_ready resets to all 1s.
  - RR pointer 0; FSM IDLE.
- Per target:
  - rb_s = rb_n_in after SYNC_STAGES flops; a pin edge appears on target_ready SYNC_STAGES cycles later.
  - mask counter loads TWB_CYC on op_done&op_expect_busy for the granted target and decrements to 0.
  - target_ready = rb_s & (mask==0).
- Timeout:
  - Counter arms on op_done&op_expect_busy and increments each cycle while !target_ready.
  - It clears and disarms when target_ready is 1.
  - On reaching TIMEOUT_CYC: timeout_err sets and the counter clears/disarms.
  - Set and err_clr in the same cycle: set wins.
- eligible = req_valid & target_ready & ~timeout_err.
- FSM, all outputs registered:
  - IDLE: if eligible!=0, pick the first eligible index at or after the RR pointer, wrapping modulo NUM_TARGETS. Go to SETUP; cen[sel] drops to 0 on that edge.
  - SETUP: hold cen[sel]=0 for CE_SETUP cycles, then go to ACTIVE; grant[sel]=1 from the first ACTIVE cycle.
  - ACTIVE: wait for op_done. On op_done, go to RELEASE and set the RR pointer to sel+1 (wrap). grant and cen[sel] deassert on that edge.
  - RELEASE: all CE high for CE_HOLD cycles, then IDLE.
- Latency: req_valid rising on a ready target in IDLE at edge k gives cen low at k+1 and grant at k+1+CE_SETUP.
- op_done outside ACTIVE is ignored (no state, mask or timeout effect).
- Dropping req_valid after selection is ignored; the grant holds until op_done.
- A target going not-ready while granted does not abort the grant.
- No more than one cen bit is ever low. grant is one-hot or zero.
- The lowest index wins only via pointer order; no fixed priority.

Decomposition:
- Package nand_arb_pkg holds:
  - FSM state enum IDLE/SETUP/ACTIVE/RELEASE.
  - Max-target localparam.
  - clog2-based width constants for the pointer and hold/setup counters.
- Sub-module nand_rb_tracker is instantiated NUM_TARGETS times. It contains the synchroniser, tWB mask counter, timeout counter and sticky error flag.
- The top level holds the round-robin selector and FSM.

Test Plan (NUM_TARGETS=4, CE_SETUP=2, CE_HOLD=2, TWB_CYC=10, TIMEOUT_CYC=100, SYNC_STAGES=2):
- Reset released with all rb_n_in=1, no requests:
  - cen=4'hF, grant=0, target_ready=4'hF, bus_busy=0.
- req_valid=4'b0001 at edge k:
  - cen=4'hE at k+1; grant=4'b0001 at k+3.
  - op_done at k+6 gives cen=4'hF and grant=0 at k+7; IDLE at k+9.
- req_valid=4'b1111 held, op_done each ACTIVE:
  - Grant order 0,1,2,3,0.
  - No two cen bits low in any cycle; always at least 2 all-high cycles between grants.
- Target 2 op_done with op_expect_busy, rb_n_in[2] kept 1:
  - target_ready[2]=0 for 10 cycles, then 1.
  - req_valid[2] is not granted during the mask.
- Target 1 busy op, then rb_n_in[1] held 0:
  - timeout_err[1]=1 exactly 100 cycles after op_done; target 1 is skipped by arbitration.
  - err_clr[1] pulse clears it.
  - err_clr in the same cycle as a set leaves timeout_err[1]=1.
- RST_N pulled low mid-ACTIVE with grant=4'b0100:
  - cen=4'hF and grant=0 immediately (asynchronously).
  - After release the FSM is in IDLE with pointer 0.

Source files
------------

// File: rtl/nand_arb_pkg.sv
// Shared types and width constants for the NAND target arbiter.
// Counter widths are sized for the largest supported target count and CE timing.
package nand_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam int MAX_TARGETS = 8;
  localparam int PTR_W       = $clog2(MAX_TARGETS);
  localparam int MAX_CE_CYC  = 15;
  localparam int CE_CNT_W    = $clog2(MAX_CE_CYC + 1);

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/nand_rb_tracker.sv
// Per-target RB# tracking: synchroniser, post-command tWB mask and sticky
// busy-timeout flag.
module nand_rb_tracker
  import nand_arb_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TWB_CYC     = 10,
  parameter int TIMEOUT_W   = 20,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic rb_n_i,
  input  logic busy_op_i,
  input  logic err_clr_i,
  output logic ready_o,
  output logic timeout_err_o
);

  localparam int                   MASK_W    = cnt_width(TWB_CYC);
  localparam logic [MASK_W-1:0]    MASK_LOAD = MASK_W'(TWB_CYC);
  localparam logic [TIMEOUT_W-1:0] TO_LAST   = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [MASK_W-1:0]      mask_q, mask_d;
  logic [TIMEOUT_W-1:0]   to_cnt_q, to_cnt_d;
  logic                   armed_q, armed_d;
  logic                   err_q, err_d;
  logic                   to_hit;

  assign ready_o       = sync_q[SYNC_STAGES-1] & (mask_q == '0);
  assign timeout_err_o = err_q;

  // The timeout only runs between a busy-causing op and the target reporting ready.
  always_comb begin
    mask_d   = mask_q;
    to_cnt_d = to_cnt_q;
    armed_d  = armed_q;
    to_hit   = 1'b0;
    if (busy_op_i) begin
      mask_d = MASK_LOAD;
    end else if (mask_q != '0) begin
      mask_d = mask_q - MASK_W'(1);
    end
    if (busy_op_i) begin
      armed_d  = 1'b1;
      to_cnt_d = '0;
    end else if (armed_q) begin
      if (ready_o) begin
        armed_d  = 1'b0;
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        to_hit   = 1'b1;
        armed_d  = 1'b0;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
      end
    end
    err_d = to_hit ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q   <= '1;
      mask_q   <= '0;
      to_cnt_q <= '0;
      armed_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rb_n_i};
      mask_q   <= mask_d;
      to_cnt_q <= to_cnt_d;
      armed_q  <= armed_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: rtl/nand_target_arbiter.sv
// Round-robin arbiter sharing one NAND bus among NUM_TARGETS chip enables,
// with CE setup/hold sequencing and per-target ready tracking.
module nand_target_arbiter
  import nand_arb_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CE_SETUP    = 2,
  parameter int CE_HOLD     = 2,
  parameter int TWB_CYC     = 10,
  parameter int TIMEOUT_W   = 20,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_TARGETS-1:0] rb_n_in,
  input  logic [NUM_TARGETS-1:0] req_valid,
  input  logic                   op_done,
  input  logic                   op_expect_busy,
  input  logic [NUM_TARGETS-1:0] err_clr,
  output logic [NUM_TARGETS-1:0] cen,
  output logic [NUM_TARGETS-1:0] grant,
  output logic                   bus_busy,
  output logic [NUM_TARGETS-1:0] target_ready,
  output logic [NUM_TARGETS-1:0] timeout_err
);

  arb_state_e             state_q, state_d;
  logic [PTR_W-1:0]       sel_q, sel_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [CE_CNT_W-1:0]    ce_cnt_q, ce_cnt_d;
  logic [NUM_TARGETS-1:0] cen_q, cen_d;
  logic [NUM_TARGETS-1:0] grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic [NUM_TARGETS-1:0] eligible;
  logic [NUM_TARGETS-1:0] busy_op;
  logic                   rr_hit;
  logic [PTR_W-1:0]       rr_idx;

  assign busy_op  = (op_done && op_expect_busy && state_q == ACTIVE) ? grant_q : '0;
  assign eligible = req_valid & target_ready & ~timeout_err;

  for (genvar t = 0; t < NUM_TARGETS; t++) begin : g_trk
    nand_rb_tracker #(
      .SYNC_STAGES(SYNC_STAGES),
      .TWB_CYC    (TWB_CYC),
      .TIMEOUT_W  (TIMEOUT_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_trk (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .rb_n_i       (rb_n_in[t]),
      .busy_op_i    (busy_op[t]),
      .err_clr_i    (err_clr[t]),
      .ready_o      (target_ready[t]),
      .timeout_err_o(timeout_err[t])
    );
  end

  // Offsets are scanned from the far end so the nearest eligible target after the pointer wins.
  always_comb begin
    int idx;
    rr_hit = 1'b0;
    rr_idx = ptr_q;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_TARGETS) idx = idx - NUM_TARGETS;
      for (int t = 0; t < NUM_TARGETS; t++) begin
        if (t == idx && eligible[t]) begin
          rr_hit = 1'b1;
          rr_idx = PTR_W'(t);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    ce_cnt_d = ce_cnt_q;
    case (state_q)
      IDLE: begin
        if (rr_hit) begin
          sel_d = rr_idx;
          if (CE_SETUP == 0) begin
            state_d = ACTIVE;
          end else begin
            state_d  = SETUP;
            ce_cnt_d = CE_CNT_W'(CE_SETUP - 1);
          end
        end
      end
      SETUP: begin
        if (ce_cnt_q == '0) state_d = ACTIVE;
        else ce_cnt_d = ce_cnt_q - CE_CNT_W'(1);
      end
      ACTIVE: begin
        if (op_done) begin
          ptr_d = (sel_q == PTR_W'(NUM_TARGETS - 1)) ? '0 : sel_q + PTR_W'(1);
          if (CE_HOLD == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = RELEASE;
            ce_cnt_d = CE_CNT_W'(CE_HOLD - 1);
          end
        end
      end
      RELEASE: begin
        if (ce_cnt_q == '0) state_d = IDLE;
        else ce_cnt_d = ce_cnt_q - CE_CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pins are registered.
  always_comb begin
    cen_d   = '1;
    grant_d = '0;
    busy_d  = (state_d != IDLE);
    for (int t = 0; t < NUM_TARGETS; t++) begin
      if (sel_d == PTR_W'(t)) begin
        if (state_d == SETUP || state_d == ACTIVE) cen_d[t] = 1'b0;
        if (state_d == ACTIVE) grant_d[t] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      ce_cnt_q <= '0;
      cen_q    <= '1;
      grant_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      ce_cnt_q <= ce_cnt_d;
      cen_q    <= cen_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
    end
  end

  assign cen      = cen_q;
  assign grant    = grant_q;
  assign bus_busy = busy_q;

endmodule

// File: tb/tb_nand_target_arbiter.sv
// Directed bench for nand_target_arbiter: latency, round robin, tWB mask,
// busy timeout and asynchronous reset.
module tb_nand_target_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] rb_n_in, req_valid, err_clr;
  logic       op_done, op_expect_busy;
  logic [3:0] cen, grant, target_ready, timeout_err;
  logic       bus_busy;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  nand_target_arbiter #(
    .NUM_TARGETS(4), .SYNC_STAGES(2), .CE_SETUP(2), .CE_HOLD(2),
    .TWB_CYC(10), .TIMEOUT_W(20), .TIMEOUT_CYC(100)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .rb_n_in(rb_n_in), .req_valid(req_valid),
    .op_done(op_done), .op_expect_busy(op_expect_busy), .err_clr(err_clr),
    .cen(cen), .grant(grant), .bus_busy(bus_busy),
    .target_ready(target_ready), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    req_valid = 4'h0; op_done = 1'b0; op_expect_busy = 1'b0;
    err_clr = 4'h0; rb_n_in = 4'hF;
    repeat (3) @(posedge CLK);
    #3 RST_N = 1'b1;
    tick();
  endtask

  task automatic wait_for_grant(output bit got);
    int n;
    n = 0;
    while (grant == 4'h0 && n < 40) begin
      tick();
      n++;
    end
    got = (grant != 4'h0);
  endtask

  task automatic finish_op();
    op_done = 1'b1; op_expect_busy = 1'b0;
    tick();
    op_done = 1'b0; req_valid = 4'h0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cen !== 4'hF) begin bad++; $display("[TB] FAIL reset_cen got=%h exp=F", cen); end
    total++; if (grant !== 4'h0) begin bad++; $display("[TB] FAIL reset_grant got=%h exp=0", grant); end
    total++; if (target_ready !== 4'hF) begin bad++; $display("[TB] FAIL reset_ready got=%h exp=F", target_ready); end
    total++; if (bus_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", bus_busy); end
    total++; if (timeout_err !== 4'h0) begin bad++; $display("[TB] FAIL reset_err got=%h exp=0", timeout_err); end
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    tick();
    total++; if (cen !== 4'hE) begin bad++; $display("[TB] FAIL single_cen_k1 got=%h exp=E", cen); end
    total++; if (grant !== 4'h0) begin bad++; $display("[TB] FAIL single_grant_k1 got=%h exp=0", grant); end
    tick();
    total++; if (grant !== 4'h0) begin bad++; $display("[TB] FAIL single_grant_k2 got=%h exp=0", grant); end
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("[TB] FAIL single_grant_k3 got=%h exp=1", grant); end
    total++; if (cen !== 4'hE) begin bad++; $display("[TB] FAIL single_cen_k3 got=%h exp=E", cen); end
    repeat (3) tick();
    op_done = 1'b1;
    tick();
    op_done = 1'b0; req_valid = 4'h0;
    total++; if (cen !== 4'hF) begin bad++; $display("[TB] FAIL single_cen_k7 got=%h exp=F", cen); end
    total++; if (grant !== 4'h0) begin bad++; $display("[TB] FAIL single_grant_k7 got=%h exp=0", grant); end
    total++; if (bus_busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_k7 got=%b exp=1", bus_busy); end
    tick();
    total++; if (bus_busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_k8 got=%b exp=1", bus_busy); end
    tick();
    total++; if (bus_busy !== 1'b0) begin bad++; $display("[TB] FAIL single_idle_k9 got=%b exp=0", bus_busy); end
  endtask

  task automatic test_op_done_ignored();
    op_done = 1'b1; op_expect_busy = 1'b1;
    tick();
    op_done = 1'b0; op_expect_busy = 1'b0;
    total++; if (target_ready !== 4'hF) begin bad++; $display("[TB] FAIL idle_opdone_ready got=%h exp=F", target_ready); end
    total++; if (bus_busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_opdone_busy got=%b exp=0", bus_busy); end
    req_valid = 4'b0001;
    tick();
    op_done = 1'b1; op_expect_busy = 1'b1;
    tick();
    op_done = 1'b0; op_expect_busy = 1'b0;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("[TB] FAIL setup_opdone_grant got=%h exp=1", grant); end
    total++; if (target_ready !== 4'hF) begin bad++; $display("[TB] FAIL setup_opdone_ready got=%h exp=F", target_ready); end
    finish_op();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int ng, cyc, high_run, zeros;
    bit prev_high;
    do_reset();
    ng = 0; cyc = 0; high_run = 0; prev_high = 1'b1;
    req_valid = 4'hF;
    while (ng < 5 && cyc < 200) begin
      tick();
      cyc++;
      zeros = 0;
      for (int t = 0; t < 4; t++) if (!cen[t]) zeros++;
      total++; if (zeros > 1) begin bad++; $display("[TB] FAIL rr_cen_onehot got=%h exp=at most one low", cen); end
      if (cen == 4'hF) begin
        high_run++;
      end else begin
        if (prev_high && ng > 0) begin
          total++; if (high_run < 2) begin bad++; $display("[TB] FAIL rr_gap got=%0d exp>=2", high_run); end
        end
        high_run = 0;
      end
      prev_high = (cen == 4'hF);
      if (op_done) begin
        op_done = 1'b0;
      end else if (grant != 4'h0) begin
        total++; if (grant !== (4'b1 << order[ng])) begin bad++; $display("[TB] FAIL rr_order_%0d got=%h exp=%h", ng, grant, 4'b1 << order[ng]); end
        ng++;
        op_done = 1'b1;
      end
    end
    total++; if (ng != 5) begin bad++; $display("[TB] FAIL rr_count got=%0d exp=5", ng); end
    req_valid = 4'h0;
    tick();
    op_done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_twb_mask();
    bit got;
    do_reset();
    req_valid = 4'b0100;
    wait_for_grant(got);
    total++; if (!got || grant !== 4'b0100) begin bad++; $display("[TB] FAIL twb_grant got=%h exp=4", grant); end
    op_done = 1'b1; op_expect_busy = 1'b1;
    tick();
    op_done = 1'b0; op_expect_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++; if (target_ready[2] !== 1'b0) begin bad++; $display("[TB] FAIL twb_mask_%0d got=%b exp=0", i, target_ready[2]); end
      total++; if (cen !== 4'hF) begin bad++; $display("[TB] FAIL twb_nogrant_%0d cen=%h exp=F", i, cen); end
      tick();
    end
    total++; if (target_ready !== 4'hF) begin bad++; $display("[TB] FAIL twb_ready_after got=%h exp=F", target_ready); end
    total++; if (cen !== 4'hF) begin bad++; $display("[TB] FAIL twb_cen_after got=%h exp=F", cen); end
    tick();
    total++; if (cen !== 4'hB) begin bad++; $display("[TB] FAIL twb_reselect got=%h exp=B", cen); end
    wait_for_grant(got);
    finish_op();
  endtask

  task automatic test_timeout();
    bit got;
    do_reset();
    req_valid = 4'b0010;
    wait_for_grant(got);
    total++; if (!got || grant !== 4'b0010) begin bad++; $display("[TB] FAIL to_grant got=%h exp=2", grant); end
    op_done = 1'b1; op_expect_busy = 1'b1; rb_n_in[1] = 1'b0;
    tick();
    op_done = 1'b0; op_expect_busy = 1'b0; req_valid = 4'h0;
    repeat (99) tick();
    total++; if (timeout_err !== 4'h0) begin bad++; $display("[TB] FAIL to_early got=%h exp=0", timeout_err); end
    tick();
    total++; if (timeout_err !== 4'b0010) begin bad++; $display("[TB] FAIL to_set got=%h exp=2", timeout_err); end
    rb_n_in[1] = 1'b1; req_valid = 4'b0010;
    repeat (4) tick();
    total++; if (target_ready[1] !== 1'b1) begin bad++; $display("[TB] FAIL to_ready got=%b exp=1", target_ready[1]); end
    total++; if (cen !== 4'hF || bus_busy !== 1'b0) begin bad++; $display("[TB] FAIL to_skip cen=%h busy=%b exp=F,0", cen, bus_busy); end
    err_clr[1] = 1'b1;
    tick();
    err_clr[1] = 1'b0;
    total++; if (timeout_err !== 4'h0) begin bad++; $display("[TB] FAIL to_clear got=%h exp=0", timeout_err); end
    tick();
    total++; if (cen !== 4'hD) begin bad++; $display("[TB] FAIL to_regrant got=%h exp=D", cen); end
    wait_for_grant(got);
    op_done = 1'b1; op_expect_busy = 1'b1; rb_n_in[1] = 1'b0;
    tick();
    op_done = 1'b0; op_expect_busy = 1'b0; req_valid = 4'h0;
    repeat (99) tick();
    err_clr[1] = 1'b1;
    tick();
    err_clr[1] = 1'b0;
    total++; if (timeout_err !== 4'b0010) begin bad++; $display("[TB] FAIL to_set_wins got=%h exp=2", timeout_err); end
    rb_n_in[1] = 1'b1; err_clr[1] = 1'b1;
    tick();
    err_clr[1] = 1'b0;
    total++; if (timeout_err !== 4'h0) begin bad++; $display("[TB] FAIL to_clear2 got=%h exp=0", timeout_err); end
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    bit got;
    do_reset();
    req_valid = 4'b0100;
    wait_for_grant(got);
    total++; if (!got || grant !== 4'b0100) begin bad++; $display("[TB] FAIL ar_grant got=%h exp=4", grant); end
    tick();
    #2 RST_N = 1'b0;
    #1;
    total++; if (cen !== 4'hF) begin bad++; $display("[TB] FAIL ar_cen got=%h exp=F", cen); end
    total++; if (grant !== 4'h0) begin bad++; $display("[TB] FAIL ar_grant_clr got=%h exp=0", grant); end
    total++; if (bus_busy !== 1'b0) begin bad++; $display("[TB] FAIL ar_busy got=%b exp=0", bus_busy); end
    req_valid = 4'hF;
    #2 RST_N = 1'b1;
    tick();
    total++; if (cen !== 4'hE) begin bad++; $display("[TB] FAIL ar_ptr0 got=%h exp=E", cen); end
    wait_for_grant(got);
    total++; if (!got || grant !== 4'b0001) begin bad++; $display("[TB] FAIL ar_grant0 got=%h exp=1", grant); end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_single();
    test_op_done_ignored();
    test_round_robin();
    test_twb_mask();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
